// File: rtl/gshare_spec_predictor_pkg.sv
// gshare_pkg: shared types and helpers for the gshare speculative predictor.
//   gs_state_t  : sweep/run control state
//   gs_upd_t    : U1->U2 update pipeline register (idx, ctr, taken, valid)
//   sat_update  : width-generic saturating counter step
// The struct fields are sized to the largest supported table/counter, and
// users cast to their own IDX_BITS/CTR_BITS. This keeps the package free of
// per-instance parameters.
package gshare_pkg;

  localparam int GS_IDX_MAX = 16;  // up to 64K counters
  localparam int GS_CTR_MAX = 8;   // up to 8-bit counters

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} gs_state_t;

  typedef struct packed {
    logic [GS_IDX_MAX-1:0] idx;
    logic [GS_CTR_MAX-1:0] ctr;
    logic                  taken;
    logic                  valid;
  } gs_upd_t;

  // Step a w-bit counter toward taken/not-taken, clamping at 0 and 2^w-1.
  function automatic logic [GS_CTR_MAX-1:0] sat_update(
    input logic [GS_CTR_MAX-1:0] old,
    input logic                  taken,
    input int unsigned           w
  );
    logic [GS_CTR_MAX-1:0] lim;
    lim = GS_CTR_MAX'((1 << w) - 1);
    if (taken) return (old >= lim) ? old : old + 1'b1;
    else       return (old == '0)  ? old : old - 1'b1;
  endfunction

endpackage

// File: rtl/gshare_spec_predictor_if.sv
// gshare_spec_predictor_if: fetch/resolve bus of the gshare predictor.
//   master : fetch + branch-resolution side (drives PCs, pushes, updates)
//   slave  : predictor side (returns predictions, history, ready)
// Signals:
//   pc_in[RD_PORTS]        fetch PCs, port 0 oldest
//   is_taken_out[RD_PORTS] combinational predictions
//   hist_out               current speculative history
//   spec_push/spec_taken   speculative history shift, per port
//   upd_*                  resolved-branch update / mispredict restore
//   ready                  low while the table is being initialised
interface gshare_spec_predictor_if #(
  parameter int PC_BITS      = 32,
  parameter int HISTORY_BITS = 8,
  parameter int RD_PORTS     = 2
) ();
  logic [RD_PORTS-1:0][PC_BITS-1:0] pc_in;
  logic [RD_PORTS-1:0]              is_taken_out;
  logic [HISTORY_BITS-1:0]          hist_out;
  logic [RD_PORTS-1:0]              spec_push;
  logic [RD_PORTS-1:0]              spec_taken;
  logic                             upd_valid;
  logic [PC_BITS-1:0]               upd_pc;
  logic [HISTORY_BITS-1:0]          upd_hist;
  logic                             upd_taken;
  logic                             upd_mispredict;
  logic                             ready;

  modport master (
    output pc_in, spec_push, spec_taken, upd_valid, upd_pc, upd_hist,
           upd_taken, upd_mispredict,
    input  is_taken_out, hist_out, ready
  );

  modport slave (
    input  pc_in, spec_push, spec_taken, upd_valid, upd_pc, upd_hist,
           upd_taken, upd_mispredict,
    output is_taken_out, hist_out, ready
  );
endinterface

// File: rtl/gshare_spec_predictor_ctr_table.sv
// gshare_ctr_table: SIZE x CTR_BITS counter storage.
//   clk_i    clock
//   raddr_i  NRD asynchronous read addresses
//   rdata_o  NRD read data
//   we_i/waddr_i/wdata_i  single synchronous write port
// No reset: contents are established by the predictor's init sweep.
module gshare_ctr_table #(
  parameter int SIZE     = 1024,
  parameter int CTR_BITS = 2,
  parameter int NRD      = 3,
  localparam int IDX_BITS = $clog2(SIZE)
) (
  input  logic                          clk_i,
  input  logic [NRD-1:0][IDX_BITS-1:0]  raddr_i,
  output logic [NRD-1:0][CTR_BITS-1:0]  rdata_o,
  input  logic                          we_i,
  input  logic [IDX_BITS-1:0]           waddr_i,
  input  logic [CTR_BITS-1:0]           wdata_i
);
  logic [CTR_BITS-1:0] mem_q [SIZE];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rdata_o[g] = mem_q[raddr_i[g]];
  end
endmodule

// File: rtl/gshare_spec_predictor.sv
// gshare_spec_predictor: multi-port gshare direction predictor with a
// speculative global history and a 2-stage read-modify-write update pipe.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          gshare_spec_predictor_if.slave (predict/push/update/ready)
//   stat_updates, stat_mispredicts  (only with GSHARE_STATS_EN defined)
// After reset the table is swept to weakly-not-taken over SIZE cycles;
// predictions read 0 and all pushes/updates are ignored until ready.
// Update pipe: U1 reads the counter (forwarded from U2 on same index),
// U2 writes the saturated result. Predictions see a write the cycle after.
module gshare_spec_predictor
  import gshare_pkg::*;
#(
  parameter int PC_BITS      = 32,
  parameter int HISTORY_BITS = 8,
  parameter int SIZE         = 1024,
  parameter int CTR_BITS     = 2,
  parameter int RD_PORTS     = 2
) (
  input  logic clk,
  input  logic rst_n,
  gshare_spec_predictor_if.slave bus
`ifdef GSHARE_STATS_EN
  , output logic [31:0] stat_updates
  , output logic [31:0] stat_mispredicts
`endif
);
  localparam int IDX_BITS = $clog2(SIZE);
  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);

  gs_state_t               state_q, state_d;
  logic [IDX_BITS-1:0]     ptr_q, ptr_d;
  logic [HISTORY_BITS-1:0] hist_q, hist_d;
  gs_upd_t                 u2_q, u2_d;
  logic                    run;

  logic [RD_PORTS:0][IDX_BITS-1:0] raddr;
  logic [RD_PORTS:0][CTR_BITS-1:0] rdata;
  logic                            we;
  logic [IDX_BITS-1:0]             waddr;
  logic [CTR_BITS-1:0]             wdata;
  logic [IDX_BITS-1:0]             idx_u;
  logic [CTR_BITS-1:0]             u1_old, u2_new;

  // pc[IDX_BITS:1] xor zero-extended history
  function automatic logic [IDX_BITS-1:0] gs_idx(
    input logic [PC_BITS-1:0]      pc,
    input logic [HISTORY_BITS-1:0] h
  );
    return IDX_BITS'(pc >> 1) ^ IDX_BITS'(h);
  endfunction

  assign run          = (state_q == RUN);
  assign bus.ready    = run;
  assign bus.hist_out = hist_q;

  // ---- prediction ports: last read port is reserved for U1 ----
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_pred
    assign raddr[p] = gs_idx(bus.pc_in[p], hist_q);
    // counter above weakly-not-taken == MSB set
    assign bus.is_taken_out[p] = run && (rdata[p] > WNT);
  end
  assign idx_u           = gs_idx(bus.upd_pc, bus.upd_hist);
  assign raddr[RD_PORTS] = idx_u;

  gshare_ctr_table #(
    .SIZE(SIZE), .CTR_BITS(CTR_BITS), .NRD(RD_PORTS + 1)
  ) u_tbl (
    .clk_i(clk), .raddr_i(raddr), .rdata_o(rdata),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata)
  );

  // ---- init sweep FSM ----
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == IDX_BITS'(SIZE - 1)) state_d = RUN;
    end
  end

  // ---- update pipe ----
  assign u2_new = CTR_BITS'(sat_update(u2_q.ctr, u2_q.taken, CTR_BITS));
  // Same-index forward so back-to-back updates accumulate.
  assign u1_old = (u2_q.valid && (u2_q.idx == GS_IDX_MAX'(idx_u))) ? u2_new
                                                                    : rdata[RD_PORTS];

  always_comb begin
    u2_d = '0;
    if (run && bus.upd_valid) begin
      u2_d.idx   = GS_IDX_MAX'(idx_u);
      u2_d.ctr   = GS_CTR_MAX'(u1_old);
      u2_d.taken = bus.upd_taken;
      u2_d.valid = 1'b1;
    end
  end

  // Single write port: sweep owns it in INIT, U2 in RUN. Gated by rst_n so
  // an in-flight U2 is dropped on the reset edge.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (rst_n) begin
      if (!run) begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = WNT;
      end else if (u2_q.valid) begin
        we    = 1'b1;
        waddr = IDX_BITS'(u2_q.idx);
        wdata = u2_new;
      end
    end
  end

  // ---- speculative history: restore wins over pushes ----
  always_comb begin
    hist_d = hist_q;
    if (run) begin
      if (bus.upd_mispredict) begin
        hist_d = {bus.upd_hist[HISTORY_BITS-2:0], bus.upd_taken};
      end else begin
        for (int p = 0; p < RD_PORTS; p++) begin
          if (bus.spec_push[p]) hist_d = {hist_d[HISTORY_BITS-2:0], bus.spec_taken[p]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      hist_q  <= '0;
      u2_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hist_q  <= hist_d;
      u2_q    <= u2_d;
    end
  end

`ifdef GSHARE_STATS_EN
  logic [31:0] stat_upd_q, stat_mis_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else if (run && bus.upd_valid) begin
      if (stat_upd_q != '1) stat_upd_q <= stat_upd_q + 32'd1;
      if (bus.upd_mispredict && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mis_q;
`endif
endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Directed bench for gshare_spec_predictor (SIZE=1024, CTR_BITS=2, 2 ports).
// Stats checks compile in when GSHARE_STATS_EN is defined.
module tb_gshare_spec_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  gshare_spec_predictor_if #(.PC_BITS(32), .HISTORY_BITS(8), .RD_PORTS(2)) bus ();
`ifdef GSHARE_STATS_EN
  logic [31:0] stat_updates, stat_mispredicts;
`endif

  gshare_spec_predictor #(
    .PC_BITS(32), .HISTORY_BITS(8), .SIZE(1024), .CTR_BITS(2), .RD_PORTS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef GSHARE_STATS_EN
    , .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
`endif
  );

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    bus.spec_push = '0; bus.spec_taken = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0;
    bus.upd_hist = '0; bus.upd_taken = 1'b0; bus.upd_mispredict = 1'b0;
  endtask

  // single update, then wait until its U2 write is visible to predictions
  task automatic upd1(input logic [31:0] pc, input logic [7:0] h, input logic t);
    bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_hist = h; bus.upd_taken = t;
    tick(); idle(); tick(); #1;
  endtask

  // n INIT cycles; counts cycles where ready or a prediction is high.
  // With stim, drives ignored updates/mispredicts/pushes near the end.
  task automatic sweep(input int n, input bit stim, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (stim && (i == n - 24 || i == n - 23)) begin
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h2B4; bus.upd_hist = 8'h00;
        bus.upd_taken = 1'b1; bus.upd_mispredict = 1'b1;
        bus.spec_push = 2'b11; bus.spec_taken = 2'b11;
      end else idle();
      #1;
      if (bus.ready !== 1'b0 || bus.is_taken_out !== 2'b00) bad++;
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    int bad;
    logic [31:0] pcs [4];
    pcs = '{32'h0, 32'h2B4, 32'h400, 32'hFFE};
    rst_n = 1'b0; idle();
    bus.pc_in[0] = 32'h2B4; bus.pc_in[1] = 32'h400;
    tick(); tick(); #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
    n_cmp++; if (bus.hist_out !== 8'h00) begin n_bad++; $display("FAIL rst_hist: got %h want 00", bus.hist_out); end
    rst_n = 1'b1;
    sweep(1024, 1'b0, bad);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL init_low: %0d bad cycles want 0", bad); end
    #1;
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL init_done: got %b want 1", bus.ready); end
    for (int i = 0; i < 4; i += 2) begin
      bus.pc_in[0] = pcs[i]; bus.pc_in[1] = pcs[i+1]; #1;
      n_cmp++; if (bus.is_taken_out !== 2'b00) begin n_bad++; $display("FAIL init_wnt%0d: got %b want 00", i, bus.is_taken_out); end
    end
  endtask

  task automatic test_forwarding();
    bus.pc_in[0] = 32'h2B4; bus.pc_in[1] = 32'h400;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h2B4; bus.upd_hist = 8'h00; bus.upd_taken = 1'b1;
    #1;
    n_cmp++; if (bus.is_taken_out[0] !== 1'b0) begin n_bad++; $display("FAIL fwd_c0: got %b want 0", bus.is_taken_out[0]); end
    tick();
    n_cmp++; if (bus.is_taken_out[0] !== 1'b0) begin n_bad++; $display("FAIL fwd_c1: got %b want 0", bus.is_taken_out[0]); end
    tick();
    n_cmp++; if (bus.is_taken_out[0] !== 1'b1) begin n_bad++; $display("FAIL fwd_c2: got %b want 1", bus.is_taken_out[0]); end
    tick(); tick(); idle(); tick(); #1;
    n_cmp++; if (bus.is_taken_out[0] !== 1'b1) begin n_bad++; $display("FAIL fwd_sat: got %b want 1", bus.is_taken_out[0]); end
    upd1(32'h2B4, 8'h00, 1'b0);  // 3 -> 2
    n_cmp++; if (bus.is_taken_out[0] !== 1'b1) begin n_bad++; $display("FAIL fwd_dec1: got %b want 1", bus.is_taken_out[0]); end
    upd1(32'h2B4, 8'h00, 1'b0);  // 2 -> 1
    n_cmp++; if (bus.is_taken_out[0] !== 1'b0) begin n_bad++; $display("FAIL fwd_dec2: got %b want 0", bus.is_taken_out[0]); end
    // two back-to-back increments from 1 must reach 3, so one decrement stays taken
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h2B4; bus.upd_hist = 8'h00; bus.upd_taken = 1'b1;
    tick(); tick(); idle(); tick();
    upd1(32'h2B4, 8'h00, 1'b0);
    n_cmp++; if (bus.is_taken_out[0] !== 1'b1) begin n_bad++; $display("FAIL fwd_pair: got %b want 1", bus.is_taken_out[0]); end
    upd1(32'h2B4, 8'h00, 1'b0);  // back to 1
  endtask

  task automatic test_saturation();
    bus.pc_in[0] = 32'h100;
    upd1(32'h100, 8'h00, 1'b0);
    n_cmp++; if (bus.is_taken_out[0] !== 1'b0) begin n_bad++; $display("FAIL sat0_a: got %b want 0", bus.is_taken_out[0]); end
    upd1(32'h100, 8'h00, 1'b0);
    n_cmp++; if (bus.is_taken_out[0] !== 1'b0) begin n_bad++; $display("FAIL sat0_b: got %b want 0", bus.is_taken_out[0]); end
    upd1(32'h100, 8'h00, 1'b1);
    n_cmp++; if (bus.is_taken_out[0] !== 1'b0) begin n_bad++; $display("FAIL sat0_c: got %b want 0", bus.is_taken_out[0]); end
    upd1(32'h100, 8'h00, 1'b1);
    n_cmp++; if (bus.is_taken_out[0] !== 1'b1) begin n_bad++; $display("FAIL sat0_d: got %b want 1", bus.is_taken_out[0]); end
    upd1(32'h100, 8'h00, 1'b1);
    upd1(32'h100, 8'h00, 1'b1);
    upd1(32'h100, 8'h00, 1'b0);
    n_cmp++; if (bus.is_taken_out[0] !== 1'b1) begin n_bad++; $display("FAIL sat3_a: got %b want 1", bus.is_taken_out[0]); end
    upd1(32'h100, 8'h00, 1'b0);
    n_cmp++; if (bus.is_taken_out[0] !== 1'b0) begin n_bad++; $display("FAIL sat3_b: got %b want 0", bus.is_taken_out[0]); end
  endtask

  task automatic test_spec_hist();
    bus.spec_push = 2'b11; bus.spec_taken = 2'b01;
    tick(); idle(); #1;
    n_cmp++; if (bus.hist_out !== 8'h02) begin n_bad++; $display("FAIL hist_push2: got %h want 02", bus.hist_out); end
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h800; bus.upd_hist = 8'h00; bus.upd_taken = 1'b0; bus.upd_mispredict = 1'b1;
    tick(); idle(); #1;
    n_cmp++; if (bus.hist_out !== 8'h00) begin n_bad++; $display("FAIL hist_restore0: got %h want 00", bus.hist_out); end
    bus.spec_push = 2'b11; bus.spec_taken = 2'b01;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h800; bus.upd_hist = 8'h5A; bus.upd_taken = 1'b1; bus.upd_mispredict = 1'b1;
    tick(); idle(); #1;
    n_cmp++; if (bus.hist_out !== 8'hB5) begin n_bad++; $display("FAIL hist_override: got %h want b5", bus.hist_out); end
    bus.spec_push = 2'b10; bus.spec_taken = 2'b11;  // port 0 taken bit not pushed
    tick(); idle(); #1;
    n_cmp++; if (bus.hist_out !== 8'h6B) begin n_bad++; $display("FAIL hist_push_p1: got %h want 6b", bus.hist_out); end
    bus.spec_push = 2'b01; bus.spec_taken = 2'b00;
    tick(); idle(); #1;
    n_cmp++; if (bus.hist_out !== 8'hD6) begin n_bad++; $display("FAIL hist_push_p0: got %h want d6", bus.hist_out); end
  endtask

  task automatic test_hist_index();
    upd1(32'h400, 8'h5A, 1'b1);  // entry 0x25A -> 2
    upd1(32'h400, 8'h5A, 1'b1);  // -> 3
    bus.pc_in[0] = 32'h400; bus.pc_in[1] = 32'h2B4; #1;
    n_cmp++; if (bus.is_taken_out !== 2'b00) begin n_bad++; $display("FAIL hidx_other: got %b want 00", bus.is_taken_out); end
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h800; bus.upd_hist = 8'h2D; bus.upd_taken = 1'b0; bus.upd_mispredict = 1'b1;
    tick(); idle(); #1;
    n_cmp++; if (bus.hist_out !== 8'h5A) begin n_bad++; $display("FAIL hidx_hist: got %h want 5a", bus.hist_out); end
    n_cmp++; if (bus.is_taken_out !== 2'b01) begin n_bad++; $display("FAIL hidx_pred: got %b want 01", bus.is_taken_out); end
    bus.pc_in[1] = 32'h400; bus.spec_push = 2'b11; bus.spec_taken = 2'b00; #1;
    n_cmp++; if (bus.is_taken_out !== 2'b11) begin n_bad++; $display("FAIL hidx_same: got %b want 11", bus.is_taken_out); end
    tick(); idle(); #1;
    n_cmp++; if (bus.hist_out !== 8'h68) begin n_bad++; $display("FAIL hidx_push: got %h want 68", bus.hist_out); end
  endtask

  task automatic test_reset_midflight();
    int bad_a, bad_b;
    bus.pc_in[0] = 32'h2B4; bus.pc_in[1] = 32'h400;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h2B4; bus.upd_hist = 8'h00; bus.upd_taken = 1'b1;
    tick(); idle();
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", bus.ready); end
    n_cmp++; if (bus.hist_out !== 8'h00) begin n_bad++; $display("FAIL mid_rst_hist: got %h want 00", bus.hist_out); end
    sweep(500, 1'b0, bad_a);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    sweep(1024, 1'b1, bad_b);
    n_cmp++; if (bad_a !== 0) begin n_bad++; $display("FAIL mid_sweep_a: %0d bad cycles want 0", bad_a); end
    n_cmp++; if (bad_b !== 0) begin n_bad++; $display("FAIL mid_sweep_b: %0d bad cycles want 0", bad_b); end
    #1;
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", bus.ready); end
    n_cmp++; if (bus.hist_out !== 8'h00) begin n_bad++; $display("FAIL mid_hist_clean: got %h want 00", bus.hist_out); end
    n_cmp++; if (bus.is_taken_out !== 2'b00) begin n_bad++; $display("FAIL mid_no_trace: got %b want 00", bus.is_taken_out); end
  endtask

`ifdef GSHARE_STATS_EN
  task automatic test_stats();
    #1;
    n_cmp++; if (stat_updates !== 32'd0) begin n_bad++; $display("FAIL stat_upd_clear: got %0d want 0", stat_updates); end
    n_cmp++; if (stat_mispredicts !== 32'd0) begin n_bad++; $display("FAIL stat_mis_clear: got %0d want 0", stat_mispredicts); end
    for (int i = 0; i < 10; i++) begin
      bus.upd_valid = 1'b1; bus.upd_pc = 32'h800; bus.upd_hist = 8'h00; bus.upd_taken = i[0];
      bus.upd_mispredict = (i == 2 || i == 5 || i == 8);
      tick();
    end
    idle(); #1;
    n_cmp++; if (stat_updates !== 32'd10) begin n_bad++; $display("FAIL stat_upd: got %0d want 10", stat_updates); end
    n_cmp++; if (stat_mispredicts !== 32'd3) begin n_bad++; $display("FAIL stat_mis: got %0d want 3", stat_mispredicts); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_saturation();
    test_spec_hist();
    test_hist_index();
    test_reset_midflight();
`ifdef GSHARE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
